// File: rtl/div_clock_monitor.sv
// Divided-clock monitor: synchronizes an external divided clock, measures every
// high and low half-period in clk cycles, checks it against expected_half +/- TOL,
// and reports lock, per-event error pulses and a 3-bit rising-edge count.
module div_clock_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_in,
    input  logic [CNT_W-1:0] expected_half,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] last_half,
    output logic             last_phase,
    output logic [2:0]       edge_cnt
);

    localparam int unsigned      GoodW   = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] HcMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TolW    = (CNT_W + 1)'(TOL);
    localparam logic [GoodW-1:0] LockCnt = GoodW'(LOCK_COUNT);

    typedef enum logic [1:0] {StIdle, StWaitEdge, StMeasure} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       hc_q, hc_d;
    logic [GoodW-1:0]       good_q, good_d;
    logic                   lock_q, lock_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       last_half_q, last_half_d;
    logic                   last_phase_q, last_phase_d;
    logic [2:0]             edge_cnt_q, edge_cnt_d;

    logic           sync_out;
    logic           edge_det;
    logic           rise_det;
    logic [CNT_W:0] hc_ext;
    logic [CNT_W:0] exp_ext;
    logic [CNT_W:0] diff;
    logic           half_good;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out ^ prev_q;
    assign rise_det = edge_det & sync_out;

    // Compare one bit wider than the counter so the absolute difference never wraps.
    assign hc_ext    = {1'b0, hc_q};
    assign exp_ext   = {1'b0, expected_half};
    assign diff      = (hc_ext >= exp_ext) ? (hc_ext - exp_ext) : (exp_ext - hc_ext);
    assign half_good = (diff <= TolW);

    // Synchronizer chain and edge-detect history; runs regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
            prev_q <= sync_out;
        end
    end

    // FSM, half counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hc_q         <= '0;
            good_q       <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            last_half_q  <= '0;
            last_phase_q <= 1'b0;
            edge_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            good_q       <= good_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            last_half_q  <= last_half_d;
            last_phase_q <= last_phase_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    // Next-state: measure on each edge, time out on a saturated counter.
    always_comb begin
        state_d      = state_q;
        hc_d         = hc_q;
        good_d       = good_q;
        lock_d       = lock_q;
        err_d        = 1'b0;
        last_half_d  = last_half_q;
        last_phase_d = last_phase_q;
        edge_cnt_d   = edge_cnt_q;

        if (!enable) begin
            state_d = StIdle;
            hc_d    = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else begin
            if ((state_q != StIdle) && rise_det) begin
                edge_cnt_d = edge_cnt_q + 3'd1;
            end
            unique case (state_q)
                StIdle: begin
                    hc_d    = '0;
                    good_d  = '0;
                    lock_d  = 1'b0;
                    state_d = StWaitEdge;
                end
                StWaitEdge: begin
                    // Alignment edge: starts the first half, produces no measurement.
                    if (edge_det) begin
                        hc_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = StMeasure;
                    end else begin
                        hc_d = '0;
                    end
                end
                StMeasure: begin
                    // An edge wins over saturation in the same cycle.
                    if (edge_det) begin
                        last_half_d  = hc_q;
                        last_phase_d = ~sync_out;
                        hc_d         = {{(CNT_W-1){1'b0}}, 1'b1};
                        if (half_good) begin
                            if (good_q != LockCnt) begin
                                good_d = good_q + GoodW'(1);
                            end
                            lock_d = (good_d == LockCnt);
                        end else begin
                            err_d  = 1'b1;
                            good_d = '0;
                            lock_d = 1'b0;
                        end
                    end else if (hc_q == HcMax) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        lock_d  = 1'b0;
                        hc_d    = '0;
                        state_d = StWaitEdge;
                    end else begin
                        hc_d = hc_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign lock       = lock_q;
    assign err        = err_q;
    assign last_half  = last_half_q;
    assign last_phase = last_phase_q;
    assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_div_clock_monitor.sv
// Directed bench for div_clock_monitor: lock, glitch, tolerance edges, timeout,
// disable and async reset, with hand-computed expectations.
module tb_div_clock_monitor;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       div_in;
    logic [7:0] expected_half;
    logic       lock;
    logic       err;
    logic [7:0] last_half;
    logic       last_phase;
    logic [2:0] edge_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_pulses = 0;
    int err_double = 0;
    int exp_err    = 0;
    logic err_prev = 1'b0;

    div_clock_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .TOL        (1),
        .LOCK_COUNT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .div_in       (div_in),
        .expected_half(expected_half),
        .lock         (lock),
        .err          (err),
        .last_half    (last_half),
        .last_phase   (last_phase),
        .edge_cnt     (edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count err pulses and flag any pulse lasting two cycles.
    always @(negedge clk) begin
        if (err) err_pulses++;
        if (err && err_prev) err_double++;
        err_prev = err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one div_in level for n clk cycles; returns #1 after the n-th edge.
    task automatic half(input logic level, input int n);
        div_in = level;
        wait_cycles(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        div_in        = 1'b0;
        expected_half = 8'd4;

        // Reset held with div_in toggling.
        for (int i = 0; i < 6; i++) begin
            wait_cycles(2);
            div_in = ~div_in;
        end
        check_eq("rst_lock", lock, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_last_half", last_half, 0);
        check_eq("rst_edge_cnt", edge_cnt, 0);
        check_eq("rst_last_phase", last_phase, 0);
        rst = 1'b0;

        // Released but disabled: nothing moves.
        for (int i = 0; i < 6; i++) begin
            half(~div_in, 4);
        end
        check_eq("dis_lock", lock, 0);
        check_eq("dis_last_half", last_half, 0);
        check_eq("dis_edge_cnt", edge_cnt, 0);
        check_eq("dis_err_pulses", err_pulses, 0);

        // Lock: alignment edge then four good halves of 4.
        half(1'b0, 4);
        enable = 1'b1;
        wait_cycles(3);
        half(1'b1, 4);
        check_eq("align_last_half", last_half, 0);
        check_eq("align_edge_cnt", edge_cnt, 1);
        half(1'b0, 4);
        half(1'b1, 4);
        half(1'b0, 4);
        check_eq("lock_after3", lock, 0);
        check_eq("lock_last_half", last_half, 4);
        check_eq("lock_last_phase_hi", last_phase, 1);
        half(1'b1, 4);
        check_eq("lock_after4", lock, 1);
        check_eq("lock_last_phase_lo", last_phase, 0);
        check_eq("lock_edge_cnt3", edge_cnt, 3);
        for (int i = 0; i < 6; i++) begin
            half(1'b0, 4);
            half(1'b1, 4);
        end
        check_eq("wrap_edge_cnt", edge_cnt, 1);
        check_eq("lock_hold", lock, 1);
        check_eq("lock_no_err", err_pulses, exp_err);

        // Glitch: a 7-cycle high phase while locked.
        half(1'b0, 4);
        half(1'b1, 7);
        half(1'b0, 4);
        exp_err++;
        check_eq("glitch_last_half", last_half, 7);
        check_eq("glitch_last_phase", last_phase, 1);
        check_eq("glitch_lock", lock, 0);
        check_eq("glitch_err", err_pulses, exp_err);
        half(1'b1, 4);
        half(1'b0, 4);
        half(1'b1, 4);
        check_eq("relock_after3", lock, 0);
        half(1'b0, 4);
        check_eq("relock_after4", lock, 1);

        // Tolerance boundaries: 3 and 5 pass, 2 and 6 fail.
        half(1'b1, 3);
        half(1'b0, 5);
        check_eq("tol3_last_half", last_half, 3);
        check_eq("tol3_lock", lock, 1);
        half(1'b1, 4);
        check_eq("tol5_last_half", last_half, 5);
        check_eq("tol5_lock", lock, 1);
        check_eq("tol35_err", err_pulses, exp_err);
        half(1'b0, 2);
        half(1'b1, 4);
        exp_err++;
        check_eq("tol2_last_half", last_half, 2);
        check_eq("tol2_lock", lock, 0);
        check_eq("tol2_err", err_pulses, exp_err);
        half(1'b0, 6);
        half(1'b1, 4);
        exp_err++;
        check_eq("tol6_last_half", last_half, 6);
        check_eq("tol6_err", err_pulses, exp_err);

        // Timeout: div_in held low long enough to saturate the counter.
        half(1'b0, 4);
        check_eq("pre_to_last_half", last_half, 4);
        check_eq("pre_to_err", err_pulses, exp_err);
        wait_cycles(300);
        exp_err++;
        check_eq("to_err", err_pulses, exp_err);
        check_eq("to_last_half", last_half, 4);
        half(1'b1, 5);
        check_eq("to_align_last_half", last_half, 4);
        check_eq("to_align_err", err_pulses, exp_err);
        half(1'b0, 5);
        check_eq("to_meas_last_half", last_half, 5);
        check_eq("to_meas_last_phase", last_phase, 1);
        check_eq("to_meas_err", err_pulses, exp_err);
        half(1'b1, 4);
        half(1'b0, 4);
        half(1'b1, 4);
        check_eq("to_relock", lock, 1);
        check_eq("to_edge_cnt", edge_cnt, 3);

        // Enable dropped mid-half.
        enable = 1'b0;
        wait_cycles(1);
        check_eq("en_drop_lock", lock, 0);
        check_eq("en_drop_last_half", last_half, 4);
        wait_cycles(2);
        half(1'b0, 4);
        check_eq("en_hold_last_half", last_half, 4);
        check_eq("en_hold_last_phase", last_phase, 0);
        check_eq("en_hold_edge_cnt", edge_cnt, 3);
        enable = 1'b1;
        wait_cycles(3);
        half(1'b1, 4);
        check_eq("en_align_edge_cnt", edge_cnt, 4);
        check_eq("en_align_last_half", last_half, 4);

        // Async reset pulse mid-half clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_last_half", last_half, 0);
        check_eq("arst_edge_cnt", edge_cnt, 0);
        check_eq("arst_lock", lock, 0);
        div_in = 1'b0;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(3);
        half(1'b1, 4);
        check_eq("arst_align_last_half", last_half, 0);
        check_eq("arst_align_edge_cnt", edge_cnt, 1);
        half(1'b0, 4);
        half(1'b1, 4);
        half(1'b0, 4);
        check_eq("arst_relock_after3", lock, 0);
        half(1'b1, 4);
        check_eq("arst_relock_after4", lock, 1);
        check_eq("arst_last_half", last_half, 4);
        check_eq("final_err_total", err_pulses, exp_err);
        check_eq("err_single_cycle", err_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_clock_monitor.md
Name: div_clock_monitor

Overview:
- Receives a divided clock from an external ripple divider chain and measures each half-period of it in system-clock cycles.
- Checks every measured half-period against an expected value plus or minus a tolerance.
- Reports lock or error, and keeps a 3-bit rising-edge count that mirrors the next divider stage.
- Sits on the input side of the divider/prescaler path as its consumer and checker.

Parameters:
SYNC_STAGES, 2, synchronizer flops on div_in (minimum 2)
CNT_W, 8, width of half-period counter and of expected_half/last_half
TOL, 1, accepted deviation in cycles, inclusive
LOCK_COUNT, 4, consecutive good half-periods required for lock

Ports:
clk  in  1  system clock; all flops on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = monitor runs; 0 = forced to IDLE
div_in  in  1  divided clock under test; asynchronous to clk
expected_half  in  CNT_W  expected high/low time in clk cycles; sampled at each detected edge
lock  out  1  registered; 1 = LOCK_COUNT consecutive good halves seen
err  out  1  registered; one-cycle pulse per bad half or timeout
last_half  out  CNT_W  most recent measured half-period
last_phase  out  1  level of div_in during the half reported in last_half (1 = high time)
edge_cnt  out  3  rising edges of div_in counted while enabled; wraps 7->0

Behaviour:
- Reset: all flops cleared asynchronously. Outputs lock=0, err=0, last_half=0, last_phase=0, edge_cnt=0. FSM=IDLE, synchronizer=0, edge-detect history=0, hc=0, good_cnt=0.
- Synchronizer: div_in passes through SYNC_STAGES flops.
- Edge detection: edge = sync_out XOR prev; prev is registered.
- Latency: take the clk edge that first samples a new div_in level as edge 1. Registered outputs reflect that transition at clk edge SYNC_STAGES+1 (edge 3 when SYNC_STAGES=2).
- Half counter hc: on a detected edge, hc<=1; otherwise hc<=hc+1, saturating at 2^CNT_W-1. A div_in half of N clk periods therefore measures N.
- FSM:
  - IDLE: hc=0, good_cnt=0, lock=0. Go to WAIT_EDGE when enable=1.
  - WAIT_EDGE: first detected edge sets hc<=1 and moves to MEASURE. This edge produces no measurement and no err.
  - MEASURE, on a detected edge:
    - last_half<=hc; last_phase<=~sync_out (the level that just ended); hc<=1.
    - Good when |hc-expected_half|<=TOL. Compute the difference unsigned-safe, one bit wider than CNT_W; no wrap.
    - Good: good_cnt++ (saturating at LOCK_COUNT). lock<=1 once good_cnt reaches LOCK_COUNT.
    - Bad: err<=1 for one cycle, good_cnt<=0, lock<=0.
  - MEASURE, hc reaches saturation with no edge: timeout. err pulse, lock<=0, good_cnt<=0, go to WAIT_EDGE. last_half is unchanged.
- enable=0 in any state: next cycle IDLE, lock=0. last_half, last_phase and edge_cnt are held. err=0 while disabled.
- edge_cnt increments on each detected rising edge while enable=1, in every non-IDLE state.
- Simultaneous edge and saturation in the same cycle: the edge wins and the half is evaluated normally with hc at its max value. No separate timeout err.
- A changed expected_half takes effect at the next detected edge only.
- Async rst mid-measurement: immediate return to reset values. The first edge after release is treated as a WAIT_EDGE edge.
- err never stays high for two cycles on one event. Back-to-back bad halves give separate pulses.

Test Plan:
1. Reset: rst=1 with div_in toggling -> lock=0, err=0, last_half=0, edge_cnt=0 throughout. After release with enable=0, outputs stay at those values.
2. Lock: enable=1, expected_half=4, div_in toggling every 4 clk -> last_half=4, err never 1, lock=1 at the 5th detected edge (1 alignment edge + 4 good halves). edge_cnt wraps 7->0 after 8 rising edges.
3. Glitch: while locked, one high phase of 7 clk -> last_half=7, last_phase=1, err high exactly 1 cycle, lock=0. Relock after 4 further good halves.
4. Tolerance boundary: expected_half=4, halves of 3 and 5 -> accepted. Halves of 2 and 6 -> err pulse each.
5. Timeout: CNT_W=8, div_in held low -> err pulse once when hc hits 255, then WAIT_EDGE. The next edge gives no err and no last_half update; the following half is measured.
6. Disruption: enable dropped mid-MEASURE -> lock=0 the next cycle, last_half held. Async rst pulse mid-half -> outputs cleared immediately; normal relock afterwards.
